// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder: two half-adder cells plus a carry flop, LSB first, one bit per clock.
// Define SERIAL_ADD_SUB_EN to add the sub_in port (A-B via inverted B and carry-in of 1).

module ha_cell (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_adder_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub_in,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s1, c1, s, c2;
   logic             sub_sel;
   logic             accept, last;

`ifdef SERIAL_ADD_SUB_EN
   assign sub_sel = sub_in;
`else
   assign sub_sel = 1'b0;
`endif

   ha_cell u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(s1), .c(c1));
   ha_cell u_ha1 (.a(s1),      .b(carry),   .s(s),  .c(c2));

   // Sum bit enters at the MSB so the result lands in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_res1
         assign res_nxt = s;
      end else begin : g_resn
         assign res_nxt = {s, res[WIDTH-1:1]};
      end
   endgenerate

   assign accept = in_valid && (state == IDLE);
   assign last   = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         a_sh  <= a_in;
         b_sh  <= b_in ^ {WIDTH{sub_sel}};
         carry <= sub_sel;
         cnt   <= '0;
      end else if (state == SHIFT) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         res   <= res_nxt;
         carry <= c1 | c2;
         cnt   <= cnt + CW'(1);
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum_out   = res;
   assign carry_out = carry;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized self-checking bench for serial_adder_seq (WIDTH=8 and WIDTH=1 instances).
`timescale 1ns/1ps

module tb_serial_adder_seq;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errs   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // WIDTH=8 instance
   logic          rst_n, in_valid, out_ready;
   logic          in_ready, out_valid, carry_out, busy;
   logic [W-1:0]  a_in, b_in, sum_out;
   logic          sub = 1'b0;

   serial_adder_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in),
`ifdef SERIAL_ADD_SUB_EN
      .sub_in(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_out(sum_out), .carry_out(carry_out), .busy(busy));

   // WIDTH=1 instance
   logic    v1_in_valid, v1_out_ready, v1_in_ready, v1_out_valid, v1_carry, v1_busy;
   logic [0:0] v1_a, v1_b, v1_sum;

   serial_adder_seq #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
      .a_in(v1_a), .b_in(v1_b),
`ifdef SERIAL_ADD_SUB_EN
      .sub_in(1'b0),
`endif
      .out_valid(v1_out_valid), .out_ready(v1_out_ready),
      .sum_out(v1_sum), .carry_out(v1_carry), .busy(v1_busy));

   // Reference: plain integer add, or A + ~B + 1 for subtract; bit W is the carry.
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      logic [W:0] r;
      if (s) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      else   r = {1'b0, a} + {1'b0, b};
      return r;
   endfunction

   // One transaction on the W=8 instance; hold = DONE cycles with out_ready low,
   // inject = pulse in_valid with different operands during SHIFT.
   task automatic txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                      input int hold, input bit inject);
      logic [W:0] e;
      int lat;
      int n;
      e = model(a, b, s);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      chk("in_ready_wait", in_ready, 1'b1);
      a_in = a; b_in = b; sub = s; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clk); lat++;
         if (inject && lat == 2) begin
            #1; in_valid = 1'b1; a_in = ~a; b_in = a ^ b;
         end
         @(negedge clk);
         if (inject && lat == 3) in_valid = 1'b0;
         if (lat == 1) chk("busy_shift", busy, 1'b1);
      end while (!out_valid && lat < 4 * W);
      in_valid = 1'b0;
      chk("latency", lat, W);
      chk("sum", sum_out, e[W-1:0]);
      chk("carry", carry_out, e[W]);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_ready", in_ready, 1'b0);
         chk("hold_sum", {carry_out, sum_out}, e);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk("post_valid", out_valid, 1'b0);
      chk("post_ready", in_ready, 1'b1);
      chk("post_keep", {carry_out, sum_out}, e);
   endtask

   logic [W:0] q[$];
   int         acc_cyc[$];

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
      v1_in_valid = 1'b0; v1_out_ready = 1'b0; v1_a = '0; v1_b = '0;
      #12;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_sum", {carry_out, sum_out}, '0);
      @(negedge clk); rst_n = 1'b1;

      // Directed cases
      txn(8'h5A, 8'h33, 1'b0, 0, 1'b0);
      txn(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      txn(8'hFF, 8'hFF, 1'b0, 5, 1'b0);
      txn(8'h12, 8'h34, 1'b0, 1, 1'b1);
`ifdef SERIAL_ADD_SUB_EN
      txn(8'h10, 8'h01, 1'b1, 0, 1'b0);
      txn(8'h01, 8'h02, 1'b1, 0, 1'b0);
`endif

      // Reset while counter == 3
      @(negedge clk);
      a_in = 8'hAA; b_in = 8'h77; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; #1;
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_sum", {carry_out, sum_out}, '0);
      @(negedge clk); rst_n = 1'b1;
      txn(8'h0F, 8'h01, 1'b0, 0, 1'b0);

      // Random transactions
      for (int i = 0; i < 25; i++) begin
         logic s;
         s = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         s = 1'($urandom_range(0, 1));
`endif
         txn(W'($urandom), W'($urandom), s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Back-to-back: in_valid and out_ready held high
      @(negedge clk);
      sub = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
      in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         logic acc;
         acc = in_ready;
         if (acc) begin
            q.push_back(model(a_in, b_in, 1'b0));
            acc_cyc.push_back(c);
         end
         if (out_valid) begin
            if (q.size() == 0) chk("b2b_spurious", 1'b1, 1'b0);
            else chk("b2b_result", {carry_out, sum_out}, q.pop_front());
         end
         @(posedge clk); #1;
         if (acc) begin a_in = W'($urandom); b_in = W'($urandom); end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b_count_ok", acc_cyc.size() >= 3, 1'b1);
      for (int i = 1; i < acc_cyc.size(); i++)
         chk("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], W + 2);

      // WIDTH=1: all operand combinations, result one cycle after acceptance
      for (int k = 0; k < 4; k++) begin
         logic [1:0] e1;
         int n;
         v1_a = 1'(k >> 1); v1_b = 1'(k);
         e1 = {1'b0, v1_a} + {1'b0, v1_b};
         @(negedge clk);
         n = 0;
         while (!v1_in_ready && n < 10) begin @(negedge clk); n++; end
         v1_in_valid = 1'b1;
         @(posedge clk); #1 v1_in_valid = 1'b0;
         @(posedge clk);
         @(negedge clk);
         chk("w1_valid", v1_out_valid, 1'b1);
         chk("w1_result", {v1_carry, v1_sum}, e1);
         v1_out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         v1_out_ready = 1'b0;
         chk("w1_idle", v1_in_ready, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errs);
      $finish;
   end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Bit-serial N-bit adder built around the team's 1-bit half-adder cell. It accepts two WIDTH-bit operands over a valid/ready handshake and streams them LSB-first through two half adders plus a carry flip-flop, one bit per clock. It collects the sum bits in a shift register and presents the WIDTH-bit result and final carry over a second valid/ready handshake. It is the sequencing stage directly upstream of, and wrapped around, the 1-bit half-adder datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; asserted low clears all state immediately.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- sub_in  input  1  present only with SERIAL_ADD_SUB_EN; 1 selects A-B.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer accepts result.
- sum_out  output  WIDTH  result bits.
- carry_out  output  1  final carry; in subtract mode this is the no-borrow flag.
- busy  output  1  high in SHIFT or DONE.

## Operation
- There are three states: IDLE, SHIFT and DONE. Reset enters IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, sum_out=0, carry_out=0, bit counter=0, carry register=0.
- **IDLE**
  - in_ready=1.
  - On a clock edge with in_valid=1, the block latches a_in into the A shift register and b_in into the B shift register.
  - The carry register is cleared and the counter is set to 0.
  - State moves to SHIFT.
- **SHIFT**, once per cycle:
  - First half adder: s1=A[0]^B[0], c1=A[0]&B[0].
  - Second half adder: s=s1^carry, c2=s1&carry.
  - Carry update: carry<=c1|c2.
  - Result register shifts right, with s entering at bit WIDTH-1. A and B shift right.
  - The counter increments. After the edge where counter==WIDTH-1, state moves to DONE.
- **DONE**
  - out_valid=1. sum_out and carry_out are stable.
  - On an edge with out_ready=1, state moves to IDLE.
  - sum_out and carry_out keep their values until the next operand acceptance.
- Result is exact modulo 2^WIDTH. carry_out is bit WIDTH of A+B.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.

## Timing
- **Acceptance:** occurs at edge E0, when in_valid & in_ready are both high.
- **Latency:** out_valid rises after edge E0+WIDTH, so it is visible for the first time in the cycle following E0+WIDTH.
- **Minimum transaction length:** WIDTH+2 cycles. This is WIDTH SHIFT cycles, at least 1 DONE cycle and 1 IDLE cycle. No operand is accepted in the same cycle as result handoff.
- **Output timing:** in_ready and out_valid are decoded combinationally from registered state only. There is no combinational path from inputs to outputs.
- **Backpressure:** if out_ready stays low, the block holds DONE indefinitely and outputs do not change.
- **Reset mid-operation:** rst_n low in any state forces IDLE at once and clears all registers and outputs to their reset values. The in-flight result is discarded.
- **WIDTH=1:** SHIFT lasts one cycle and out_valid appears one cycle after acceptance.

## Configuration
- Macro: SERIAL_ADD_SUB_EN.
- **Defined:**
  - The sub_in port exists and is latched at acceptance.
  - When sub_in=1, B is stored inverted and the carry register is initialised to 1, which yields A-B in two's complement.
  - carry_out=1 means A>=B (unsigned).
  - When sub_in=0, behaviour is identical to add-only.
- **Undefined:** sub_in is absent and the block is add-only. The carry register always starts at 0.

## Test plan
- **Basic add:** WIDTH=8, a_in=0x5A, b_in=0x33 -> out_valid 8 cycles after acceptance, sum_out=0x8D, carry_out=0.
- **Overflow:** a_in=0xFF, b_in=0x01 -> sum_out=0x00, carry_out=1. Then a_in=0xFF, b_in=0xFF -> sum_out=0xFE, carry_out=1.
- **Backpressure and ignored input:**
  - Hold out_ready=0 for 5 cycles after out_valid rises -> out_valid, sum_out and carry_out are unchanged throughout and in_ready=0.
  - Pulse in_valid with new operands during SHIFT -> they are ignored and the result matches the first operands.
- **Reset mid-SHIFT:** assert rst_n=0 at counter=3 -> immediately in_ready=1, out_valid=0, busy=0, sum_out=0, carry_out=0. The next transaction 0x0F+0x01 -> 0x10.
- **Subtract (SERIAL_ADD_SUB_EN defined):**
  - sub_in=1, a_in=0x10, b_in=0x01 -> sum_out=0x0F, carry_out=1.
  - sub_in=1, a_in=0x01, b_in=0x02 -> sum_out=0xFF, carry_out=0.
- **Edge width and back-to-back:**
  - WIDTH=1: 1+1 -> sum_out=0, carry_out=1, out_valid one cycle after acceptance.
  - With in_valid and out_ready held high, new operands are accepted every WIDTH+2 cycles.
